// File: rtl/vram_arbiter.sv
// VRAM access scheduler: one VDP access per slot, refresh when due, aux port in idle time.
// Every grant copies its request into command registers so a new slot can queue behind a running access.
module vram_arbiter #(
    parameter int REFRESH_INTERVAL = 840,
    parameter int ADDR_W           = 21
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vdp_dlclk,
    input  logic              vdp_dhclk,
    input  logic              vdp_we_n,
    input  logic [16:0]       vdp_addr,
    input  logic [7:0]        vdp_wdata,
    output logic [15:0]       vdp_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [16:0]       aux_addr,
    input  logic [7:0]        aux_wdata,
    output logic [7:0]        aux_rdata,
    output logic              aux_ack,
    output logic              mc_read,
    output logic              mc_write,
    output logic              mc_refresh,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [15:0]       mc_din,
    output logic [1:0]        mc_wdm,
    input  logic [15:0]       mc_dout,
    input  logic              mc_busy,
    output logic              vdp_overrun
);

    // Waiting for busy to rise is handled inside ST_ISSUE, so no separate wait-for-accept state exists.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [1:0] OWN_VDP = 2'd0;
    localparam logic [1:0] OWN_REF = 2'd1;
    localparam logic [1:0] OWN_AUX = 2'd2;

    localparam int CNT_MAX = 2 * REFRESH_INTERVAL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_DUE = CNT_W'(REFRESH_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_URG = CNT_W'(CNT_MAX - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             cmd_we_q, cmd_we_d;
    logic [16:0]      cmd_addr_q, cmd_addr_d;
    logic [7:0]       cmd_wdata_q, cmd_wdata_d;
    logic             phase_hi_q, phase_hi_d;
    logic             slot_start_q, slot_start_d;
    logic             vdp_pend_q, vdp_pend_d;
    logic             pend_we_n_q, pend_we_n_d;
    logic [16:0]      pend_addr_q, pend_addr_d;
    logic [7:0]       pend_wdata_q, pend_wdata_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [15:0]      vdp_rdata_q, vdp_rdata_d;
    logic [7:0]       aux_rdata_q, aux_rdata_d;
    logic             aux_ack_q, aux_ack_d;
    logic             overrun_q, overrun_d;

    logic        phase_both, phase_none;
    logic        ref_due, ref_urgent;
    logic        vdp_inflight, vdp_want;
    logic        src_we_n;
    logic [16:0] src_addr;
    logic [7:0]  src_wdata;
    logic        issuing, cmd_go;

    always_comb begin
        phase_both   = vdp_dlclk & vdp_dhclk;
        phase_none   = ~vdp_dlclk & ~vdp_dhclk;
        ref_due      = (ref_cnt_q >= CNT_DUE);
        ref_urgent   = (ref_cnt_q >= CNT_URG);
        vdp_inflight = (state_q != ST_IDLE) && (owner_q == OWN_VDP);
        vdp_want     = vdp_pend_q | slot_start_q;
        // A slot arriving this cycle is granted straight from the port, bypassing the pending copy.
        src_we_n     = slot_start_q ? vdp_we_n  : pend_we_n_q;
        src_addr     = slot_start_q ? vdp_addr  : pend_addr_q;
        src_wdata    = slot_start_q ? vdp_wdata : pend_wdata_q;

        state_d      = state_q;
        owner_d      = owner_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        phase_hi_d   = phase_both;
        slot_start_d = phase_both & ~phase_hi_q;
        vdp_pend_d   = vdp_pend_q;
        pend_we_n_d  = pend_we_n_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        ref_cnt_d    = (ref_cnt_q == CNT_SAT) ? ref_cnt_q : ref_cnt_q + CNT_W'(1);
        vdp_rdata_d  = vdp_rdata_q;
        aux_rdata_d  = aux_rdata_q;
        aux_ack_d    = 1'b0;
        overrun_d    = overrun_q;

        if (slot_start_q) begin
            vdp_pend_d   = 1'b1;
            pend_we_n_d  = vdp_we_n;
            pend_addr_d  = vdp_addr;
            pend_wdata_d = vdp_wdata;
            if (vdp_pend_q || vdp_inflight) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!mc_busy) begin
                    if (vdp_want) begin
                        state_d     = ST_ISSUE;
                        owner_d     = OWN_VDP;
                        cmd_we_d    = ~src_we_n;
                        cmd_addr_d  = src_addr;
                        cmd_wdata_d = src_wdata;
                        vdp_pend_d  = 1'b0;
                    end else if ((ref_due && phase_none) || (ref_urgent && !phase_both)) begin
                        state_d     = ST_ISSUE;
                        owner_d     = OWN_REF;
                        cmd_we_d    = 1'b0;
                        cmd_addr_d  = '0;
                        cmd_wdata_d = '0;
                        ref_cnt_d   = '0;
                    end else if (aux_req && !phase_both && !ref_urgent && !aux_ack_q) begin
                        state_d     = ST_ISSUE;
                        owner_d     = OWN_AUX;
                        cmd_we_d    = aux_we;
                        cmd_addr_d  = aux_addr;
                        cmd_wdata_d = aux_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (mc_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!mc_busy) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_VDP && !cmd_we_q) begin
                        vdp_rdata_d = mc_dout;
                    end
                    if (owner_q == OWN_AUX) begin
                        aux_ack_d = 1'b1;
                        if (!cmd_we_q) begin
                            aux_rdata_d = cmd_addr_q[16] ? mc_dout[15:8] : mc_dout[7:0];
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_VDP;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            phase_hi_q   <= 1'b0;
            slot_start_q <= 1'b0;
            vdp_pend_q   <= 1'b0;
            pend_we_n_q  <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            ref_cnt_q    <= '0;
            vdp_rdata_q  <= '0;
            aux_rdata_q  <= '0;
            aux_ack_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            phase_hi_q   <= phase_hi_d;
            slot_start_q <= slot_start_d;
            vdp_pend_q   <= vdp_pend_d;
            pend_we_n_q  <= pend_we_n_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            ref_cnt_q    <= ref_cnt_d;
            vdp_rdata_q  <= vdp_rdata_d;
            aux_rdata_q  <= aux_rdata_d;
            aux_ack_q    <= aux_ack_d;
            overrun_q    <= overrun_d;
        end
    end

    // Commands fall combinationally once busy is seen, so they never overlap the controller's access.
    assign issuing     = (state_q == ST_ISSUE);
    assign cmd_go      = issuing & ~mc_busy;
    assign mc_read     = cmd_go & (owner_q != OWN_REF) & ~cmd_we_q;
    assign mc_write    = cmd_go & (owner_q != OWN_REF) & cmd_we_q;
    assign mc_refresh  = cmd_go & (owner_q == OWN_REF);
    assign mc_addr     = issuing ? ADDR_W'(cmd_addr_q[15:0]) : '0;
    assign mc_din      = issuing ? {cmd_wdata_q, cmd_wdata_q} : 16'h0000;
    assign mc_wdm      = issuing ? {~cmd_addr_q[16], cmd_addr_q[16]} : 2'b00;
    assign vdp_rdata   = vdp_rdata_q;
    assign aux_rdata   = aux_rdata_q;
    assign aux_ack     = aux_ack_q;
    assign vdp_overrun = overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus randomized byte traffic against a reference memory.
// A small memory-controller model answers commands with a fixed busy window.
module tb_vram_arbiter;

    localparam int RI       = 840;
    localparam int AW       = 21;
    localparam int BUSY_LEN = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vdp_dlclk, vdp_dhclk, vdp_we_n;
    logic [16:0]   vdp_addr;
    logic [7:0]    vdp_wdata;
    logic [15:0]   vdp_rdata;
    logic          aux_req, aux_we;
    logic [16:0]   aux_addr;
    logic [7:0]    aux_wdata, aux_rdata;
    logic          aux_ack;
    logic          mc_read, mc_write, mc_refresh;
    logic [AW-1:0] mc_addr;
    logic [15:0]   mc_din;
    logic [1:0]    mc_wdm;
    logic [15:0]   mc_dout;
    logic          mc_busy;
    logic          vdp_overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    bit [15:0] mem [0:65535];
    int        busy_left;
    logic      pre_en = 1'b0;
    logic [15:0] pre_addr = 16'h0, pre_data = 16'h0;
    int        cmd_log[$];
    int        op_log[$];
    bit [7:0]  ref_mem [8][2];

    vram_arbiter #(.REFRESH_INTERVAL(RI), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .vdp_dlclk(vdp_dlclk), .vdp_dhclk(vdp_dhclk), .vdp_we_n(vdp_we_n),
        .vdp_addr(vdp_addr), .vdp_wdata(vdp_wdata), .vdp_rdata(vdp_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_rdata(aux_rdata), .aux_ack(aux_ack),
        .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
        .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm), .mc_dout(mc_dout),
        .mc_busy(mc_busy), .vdp_overrun(vdp_overrun)
    );

    always #5 clk = ~clk;

    // Controller model: accepts a command when idle, stays busy BUSY_LEN cycles; wdm bit 1 masks that byte.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mc_busy   <= 1'b0;
            busy_left <= 0;
            mc_dout   <= 16'h0;
        end else begin
            if (pre_en) mem[pre_addr] <= pre_data;
            if (mc_busy) begin
                if (busy_left <= 1) mc_busy <= 1'b0;
                busy_left <= busy_left - 1;
            end else if (mc_read | mc_write | mc_refresh) begin
                mc_busy   <= 1'b1;
                busy_left <= BUSY_LEN;
                if (mc_read) mc_dout <= mem[mc_addr[15:0]];
                if (mc_write) begin
                    if (!mc_wdm[0]) mem[mc_addr[15:0]][7:0]  <= mc_din[7:0];
                    if (!mc_wdm[1]) mem[mc_addr[15:0]][15:8] <= mc_din[15:8];
                end
                cmd_log.push_back(int'(mc_addr[15:0]));
                op_log.push_back((32'(mc_read) + 32'(mc_write) + 32'(mc_refresh) > 1) ? 3 :
                                 mc_refresh ? 2 : (mc_write ? 1 : 0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_phase(input logic [1:0] p);
        {vdp_dlclk, vdp_dhclk} = p;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic do_aux(input bit we, input logic [16:0] a, input logic [7:0] wd,
                          input bit chk, input logic [7:0] exp_rd, input string tag);
        bit got = 0;
        aux_we = we; aux_addr = a; aux_wdata = wd; aux_req = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (aux_ack) got = 1;
        end
        aux_req = 1'b0;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("[TB] FAIL %s_ack: got no aux_ack, required one within 200 cycles", tag);
        end else if (chk) begin
            tests_run++;
            if (aux_rdata !== exp_rd) begin
                tests_failed++;
                $display("[TB] FAIL %s_rdata: got %02h required %02h", tag, aux_rdata, exp_rd);
            end
        end
        tick();
        tests_run++;
        if (aux_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_ack_width: aux_ack got %b required 0", tag, aux_ack);
        end
    endtask

    task automatic do_vdp(input logic we_n, input logic [16:0] a, input logic [7:0] wd);
        vdp_we_n = we_n; vdp_addr = a; vdp_wdata = wd;
        set_phase(2'b11);
        repeat (3) tick();
        set_phase(2'b00);
        repeat (30) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({mc_read, mc_write, mc_refresh} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_cmds: got %b required 000", {mc_read, mc_write, mc_refresh});
        end
        tests_run++;
        if ({aux_ack, vdp_overrun} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b required 00", {aux_ack, vdp_overrun});
        end
        tests_run++;
        if ({vdp_rdata, aux_rdata} !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rdata: got %06h required 000000", {vdp_rdata, aux_rdata});
        end
        tests_run++;
        if ({mc_addr, mc_din, mc_wdm} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: addr %h din %h wdm %b required all zero", mc_addr, mc_din, mc_wdm);
        end
        reset_n = 1'b1;
        set_phase(2'b01);
        repeat (3) tick();
        tests_run++;
        if ({mc_read, mc_write, mc_refresh} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_cmd: got %b required 000", {mc_read, mc_write, mc_refresh});
        end
    endtask

    task automatic test_vdp_read();
        preload(16'h0123, 16'hBEEF);
        vdp_we_n = 1'b1; vdp_addr = 17'h10123; vdp_wdata = 8'h00;
        set_phase(2'b11);
        tick();
        tests_run++;
        if (mc_read !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_early: mc_read got %b required 0 one clock after phase", mc_read);
        end
        tick();
        tests_run++;
        if ({mc_read, mc_write, mc_refresh} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL read_cmd: got %b required 100 two clocks after phase", {mc_read, mc_write, mc_refresh});
        end
        tests_run++;
        if (mc_addr !== 21'h00123 || mc_wdm !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL read_addr: addr %h wdm %b required 00123 01", mc_addr, mc_wdm);
        end
        tick();
        set_phase(2'b01);
        repeat (12) tick();
        tests_run++;
        if (vdp_rdata !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL read_data: vdp_rdata got %h required BEEF", vdp_rdata);
        end
    endtask

    task automatic test_vdp_write();
        int acks = 0;
        vdp_we_n = 1'b0; vdp_addr = 17'h00040; vdp_wdata = 8'h5A;
        set_phase(2'b11);
        repeat (2) tick();
        tests_run++;
        if ({mc_read, mc_write} !== 2'b01 || mc_din !== 16'h5A5A || mc_wdm !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL write_cmd: rd/wr %b din %h wdm %b required 01 5A5A 10",
                     {mc_read, mc_write}, mc_din, mc_wdm);
        end
        tick();
        set_phase(2'b01);
        repeat (12) begin
            tick();
            if (aux_ack) acks++;
        end
        tests_run++;
        if (acks != 0) begin
            tests_failed++;
            $display("[TB] FAIL write_no_ack: aux_ack cycles got %0d required 0", acks);
        end
        tests_run++;
        if (mem[16'h0040] !== 16'h005A) begin
            tests_failed++;
            $display("[TB] FAIL write_mem: word got %h required 005A", mem[16'h0040]);
        end
        tests_run++;
        if (vdp_rdata !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL write_keeps_rdata: vdp_rdata got %h required BEEF", vdp_rdata);
        end
    endtask

    task automatic test_aux_read();
        preload(16'h0200, 16'h12AB);
        do_aux(1'b0, 17'h10200, 8'h00, 1'b1, 8'h12, "aux_read_hi");
        do_aux(1'b0, 17'h00200, 8'h00, 1'b1, 8'hAB, "aux_read_lo");
    endtask

    task automatic test_aux_defer();
        int base = cmd_log.size();
        bit got = 0;
        vdp_we_n = 1'b1; vdp_addr = 17'h00123;
        aux_we = 1'b0; aux_addr = 17'h00200; aux_req = 1'b1;
        set_phase(2'b11);
        repeat (3) tick();
        set_phase(2'b01);
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (aux_ack) got = 1;
        end
        aux_req = 1'b0;
        tests_run++;
        if (!got || aux_rdata !== 8'hAB) begin
            tests_failed++;
            $display("[TB] FAIL defer_aux: ack %b rdata %02h required 1 AB", got, aux_rdata);
        end
        tests_run++;
        if (cmd_log.size() < base + 2) begin
            tests_failed++;
            $display("[TB] FAIL defer_order: commands got %0d required 2", cmd_log.size() - base);
        end else if (cmd_log[base] != 32'h123 || cmd_log[base+1] != 32'h200) begin
            tests_failed++;
            $display("[TB] FAIL defer_order: got %h then %h required 0123 then 0200",
                     cmd_log[base], cmd_log[base+1]);
        end
        tests_run++;
        if (vdp_rdata !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL defer_vdp: vdp_rdata got %h required BEEF", vdp_rdata);
        end
        tick();
    endtask

    task automatic test_overrun();
        int base;
        preload(16'h0124, 16'h5555);
        base = cmd_log.size();
        vdp_we_n = 1'b1; vdp_addr = 17'h00123;
        set_phase(2'b11);
        repeat (3) tick();
        set_phase(2'b00);
        repeat (2) tick();
        tests_run++;
        if (vdp_overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL overrun_pre: got %b required 0", vdp_overrun);
        end
        vdp_addr = 17'h00124;
        set_phase(2'b11);
        repeat (3) tick();
        tests_run++;
        if (vdp_overrun !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_set: got %b required 1", vdp_overrun);
        end
        set_phase(2'b01);
        repeat (25) tick();
        tests_run++;
        if (vdp_overrun !== 1'b1 || vdp_rdata !== 16'h5555) begin
            tests_failed++;
            $display("[TB] FAIL overrun_second: overrun %b rdata %h required 1 5555", vdp_overrun, vdp_rdata);
        end
        tests_run++;
        if (cmd_log.size() < base + 2 || cmd_log[base] != 32'h123 || cmd_log[base+1] != 32'h124) begin
            tests_failed++;
            $display("[TB] FAIL overrun_order: %0d commands logged, required 0123 then 0124",
                     cmd_log.size() - base);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int stray = 0;
        aux_we = 1'b1; aux_addr = 17'h00050; aux_wdata = 8'h77; aux_req = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (mc_write) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_issue: mc_write got 0 required 1 within 50 cycles");
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({mc_read, mc_write, mc_refresh} !== 3'b000 || vdp_overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_drop: cmds %b overrun %b required 000 0",
                     {mc_read, mc_write, mc_refresh}, vdp_overrun);
        end
        aux_req = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) begin
            tick();
            if (mc_read | mc_write | mc_refresh) stray++;
        end
        tests_run++;
        if (stray != 0 || mem[16'h0050] !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_idle: stray cmds %0d word %h required 0 0000", stray, mem[16'h0050]);
        end
    endtask

    task automatic test_refresh();
        int t[3];
        int n = 0;
        int cyc = 0;
        set_phase(2'b00);
        for (int i = 0; i < 4000 && n < 3; i++) begin
            tick();
            cyc++;
            if (mc_refresh) begin
                t[n] = cyc;
                n++;
                if (n == 2) set_phase(2'b01);
            end
        end
        tests_run++;
        if (n < 3) begin
            tests_failed++;
            $display("[TB] FAIL refresh_count: got %0d refreshes required 3 within 4000 cycles", n);
        end else begin
            tests_run++;
            if (t[1] - t[0] != RI + 1) begin
                tests_failed++;
                $display("[TB] FAIL refresh_due_gap: got %0d required %0d", t[1] - t[0], RI + 1);
            end
            tests_run++;
            if (t[2] - t[1] != 2 * RI) begin
                tests_failed++;
                $display("[TB] FAIL refresh_urgent_gap: got %0d required %0d", t[2] - t[1], 2 * RI);
            end
        end
    endtask

    task automatic test_random();
        int w, lane, op;
        logic [7:0] d;
        logic [16:0] a;
        set_phase(2'b00);
        for (int i = 0; i < 24; i++) begin
            w = $urandom_range(0, 7);
            lane = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            d = 8'($urandom);
            a = {lane[0], 16'(16'h0300 + w)};
            case (op)
                0: begin
                    do_aux(1'b1, a, d, 1'b0, 8'h00, "rnd_aux_wr");
                    ref_mem[w][lane] = d;
                end
                1: do_aux(1'b0, a, 8'h00, 1'b1, ref_mem[w][lane], "rnd_aux_rd");
                2: begin
                    do_vdp(1'b0, a, d);
                    ref_mem[w][lane] = d;
                end
                default: begin
                    do_vdp(1'b1, a, 8'h00);
                    tests_run++;
                    if (vdp_rdata !== {ref_mem[w][1], ref_mem[w][0]}) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_vdp_rd: word %0d got %h required %h",
                                 w, vdp_rdata, {ref_mem[w][1], ref_mem[w][0]});
                    end
                end
            endcase
        end
        for (int k = 0; k < 16; k++) begin
            do_aux(1'b0, {k[0], 16'(16'h0300 + k / 2)}, 8'h00, 1'b1, ref_mem[k / 2][k % 2], "sweep_rd");
        end
        tests_run++;
        if (vdp_overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rnd_overrun: got %b required 0", vdp_overrun);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        vdp_dlclk = 1'b0; vdp_dhclk = 1'b0; vdp_we_n = 1'b1;
        vdp_addr = '0; vdp_wdata = '0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
        test_reset();
        test_vdp_read();
        test_vdp_write();
        test_aux_read();
        test_aux_defer();
        test_overrun();
        test_reset_mid();
        test_refresh();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Scheduler between the V9958 VDP core, SDRAM refresh and one auxiliary byte port (loader/debug) in front of the single `memory_controller` VRAM instance. It decodes the VDP slot phase (`VideoDLClk`/`VideoDHClk`) into one access per slot and issues refresh only when a configurable interval has elapsed. Auxiliary requests go into the remaining idle time. It replaces the combinational read/write/refresh gating at the top level and runs entirely in the memory-controller clock domain.

## Interface
Parameters:
- REFRESH_INTERVAL, 840: clocks between required refreshes (7.8 µs at 108 MHz).
- ADDR_W, 21: controller address width.

Ports:
- clk  in  1  controller clock; phase inputs are synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- vdp_dlclk, vdp_dhclk  in  1  VDP slot phase; both high = VDP slot, both low = refresh window.
- vdp_we_n  in  1  0 = write slot.
- vdp_addr  in  17  bit 16 selects byte lane, [15:0] word address.
- vdp_wdata  in  8  write byte.
- vdp_rdata  out  16  last VDP read word.
- aux_req  in  1  level request, held until aux_ack.
- aux_we  in  1  1 = write.
- aux_addr  in  17  same mapping as vdp_addr.
- aux_wdata  in  8  write byte.
- aux_rdata  out  8  lane-selected read byte.
- aux_ack  out  1  one-cycle completion pulse.
- mc_read, mc_write, mc_refresh  out  1  controller commands.
- mc_addr  out  ADDR_W  {zero pad, addr[15:0]}.
- mc_din  out  16  {byte, byte}.
- mc_wdm  out  2  {~addr[16], addr[16]}.
- mc_dout  in  16  controller read data.
- mc_busy  in  1  controller busy.
- vdp_overrun  out  1  sticky; set when a VDP slot arrives while the previous VDP access is unfinished.

## Operation
- slot_start is registered rising edge of (dlclk & dhclk). On slot_start, latch we_n, addr, wdata into VDP pending register and set vdp_pend.
- Refresh counter: increments every clk, saturates at 2*REFRESH_INTERVAL, clears to 0 on refresh issue. ref_due when count ≥ REFRESH_INTERVAL; ref_urgent when count ≥ 2*REFRESH_INTERVAL-1.
- FSM states: IDLE, ISSUE, WAIT_ACC, WAIT_DONE.
- IDLE arbitration, evaluated every cycle, with the highest-priority true condition winning:
  - 1: vdp_pend.
  - 2: ref_due while phase = 00, or ref_urgent while phase ≠ 11.
  - 3: aux_req while phase ≠ 11 and not ref_urgent.
- IDLE with mc_busy = 1 issues nothing.
- The grant records owner ∈ {VDP, REF, AUX}. The FSM then moves to ISSUE.
- ISSUE: drives exactly one of mc_read/mc_write/mc_refresh, plus addr, din and wdm from the owner's registers. These are held until mc_busy = 1, then the FSM goes to WAIT_DONE. Command outputs drop in the cycle busy is seen.
- WAIT_DONE: on mc_busy = 0, complete the access and return to IDLE.
  - VDP read: vdp_rdata <= mc_dout. Clear vdp_pend.
  - AUX read: aux_rdata <= addr[16] ? mc_dout[15:8] : mc_dout[7:0].
  - AUX (read or write): pulse aux_ack.
  - REF: refresh counter has already been cleared at issue.
- WAIT_ACC is reserved for an issued command that has not yet seen busy. Implementations may merge it into ISSUE.
- Overrun: slot_start while vdp_pend = 1 and not yet issued → replace the pending contents and set vdp_overrun. slot_start while the VDP access is in ISSUE/WAIT_DONE → set vdp_overrun and queue the new request as pending.
- Write data lanes: mc_din = {wdata, wdata}. mc_wdm masks the unselected byte.

## Timing
- Reset values: all outputs 0, FSM IDLE, counter 0, vdp_pend 0, vdp_overrun 0.
- slot_start registered 1 cycle after phase reaches 11. mc_read/mc_write asserted the following cycle if IDLE and not busy. Latency from phase = 11 to command is 2 clocks.
- Commands are level outputs, never asserted in two consecutive accesses without an intervening IDLE cycle.
- aux_ack is high exactly 1 cycle, the cycle after busy falls. aux_req sampled again no earlier than the cycle after aux_ack.
- Simultaneous slot_start and IDLE aux/ref grant in the same cycle: the VDP wins.
- Reset mid-access drops commands immediately. The controller's own reset handles the SDRAM.

## Test plan
- Read slot: phase 11, we_n = 1, addr = 0x1_0123, busy high for 6 cycles, mc_dout = 0xBEEF → mc_read 2 clocks after phase, mc_addr = 0x00123, mc_wdm = 2'b01, vdp_rdata = 0xBEEF.
- Write slot: we_n = 0, addr = 0x0_0040, wdata = 0x5A → mc_write, mc_din = 0x5A5A, mc_wdm = 2'b10, no aux_ack.
- Refresh: idle 840 clocks, phase 00 → single mc_refresh pulse. With phase held 01, no refresh until count 1679, then urgent refresh.
- Aux read: aux_req, addr = 0x1_0200, mc_dout = 0x12AB → aux_rdata = 0x12, aux_ack for 1 cycle. Repeat with aux_req pending and phase 11: deferred until the VDP access completes.
- Overrun: second slot_start while first VDP read in WAIT_DONE → vdp_overrun = 1 and remains 1 until reset_n low. The second access is still issued.
- Reset: assert reset_n low during ISSUE → all mc_* commands 0 immediately, FSM IDLE after release.
